// File: rtl/adpll_lock_det_5bit.sv
// Frequency lock detector for an ADPLL: counts feedback edges over a window of
// 2^WIN_LOG2 reference edges and tracks lock through a small debounce FSM.
module adpll_lock_det_5bit #(
  parameter int WIN_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clk_ref,
  input  logic       fb_clk,
  input  logic [4:0] tol,
  input  logic [4:0] lock_thresh,
  output logic [7:0] fb_count,
  output logic [4:0] freq_err,
  output logic       freq_err_sign,
  output logic       meas_valid,
  output logic       locked,
  output logic       lock_lost
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_ACQ    = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam logic [8:0]          WIN_EDGES = 9'd1 << WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] REF_LAST  = '1;

  logic [2:0]          r_ref_sync;
  logic [2:0]          r_fb_sync;
  logic [WIN_LOG2-1:0] r_ref_cnt;
  logic [7:0]          r_fb_cnt;
  logic [4:0]          r_good_cnt;
  logic [2:0]          r_state;

  logic                w_ref_rise;
  logic                w_fb_rise;
  logic                w_close;
  logic [7:0]          w_fb_total;
  logic [8:0]          w_total9;
  logic                w_under;
  logic [8:0]          w_diff;
  logic [4:0]          w_err;
  logic                w_good;
  logic [4:0]          w_thresh;
  logic [5:0]          w_good_inc;
  logic [2:0]          w_state_next;
  logic [4:0]          w_good_next;
  logic                w_lost_next;

  // Bits [1:0] are the metastability pair, bit [2] is the edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ref_sync <= 3'b000;
      r_fb_sync  <= 3'b000;
    end else begin
      r_ref_sync <= {r_ref_sync[1:0], clk_ref};
      r_fb_sync  <= {r_fb_sync[1:0], fb_clk};
    end
  end

  assign w_ref_rise = r_ref_sync[1] & ~r_ref_sync[2];
  assign w_fb_rise  = r_fb_sync[1] & ~r_fb_sync[2];

  // An fb edge landing on the closing ref edge belongs to the closing window.
  assign w_fb_total = (w_fb_rise && (r_fb_cnt != 8'hFF)) ? r_fb_cnt + 8'd1 : r_fb_cnt;
  assign w_close    = en && w_ref_rise && (r_ref_cnt == REF_LAST);

  assign w_total9   = {1'b0, w_fb_total};
  assign w_under    = w_total9 < WIN_EDGES;
  assign w_diff     = w_under ? (WIN_EDGES - w_total9) : (w_total9 - WIN_EDGES);
  assign w_err      = (w_diff > 9'd31) ? 5'd31 : w_diff[4:0];
  assign w_good     = w_err <= tol;
  assign w_thresh   = (lock_thresh == 5'd0) ? 5'd1 : lock_thresh;
  assign w_good_inc = {1'b0, r_good_cnt} + 6'd1;

  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good_cnt;
    w_lost_next  = 1'b0;
    if (!en) begin
      w_state_next = S_IDLE;
      w_good_next  = 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_SYNC;
        end
        S_SYNC: begin
          if (w_close) w_state_next = S_ACQ;
        end
        S_ACQ: begin
          if (w_close) begin
            if (!w_good) begin
              w_good_next = 5'd0;
            end else if (w_good_inc >= {1'b0, w_thresh}) begin
              w_state_next = S_LOCKED;
              w_good_next  = 5'd0;
            end else begin
              w_good_next = w_good_inc[4:0];
            end
          end
        end
        S_LOCKED: begin
          if (w_close && !w_good) w_state_next = S_HOLD;
        end
        S_HOLD: begin
          if (w_close) begin
            if (w_good) begin
              w_state_next = S_LOCKED;
            end else begin
              w_state_next = S_ACQ;
              w_good_next  = 5'd0;
              w_lost_next  = 1'b1;
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_good_next  = 5'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ref_cnt <= '0;
      r_fb_cnt  <= 8'd0;
    end else if (!en) begin
      r_ref_cnt <= '0;
      r_fb_cnt  <= 8'd0;
    end else begin
      if (w_ref_rise) r_ref_cnt <= r_ref_cnt + 1'b1;
      r_fb_cnt <= w_close ? 8'd0 : w_fb_total;
    end
  end

  // Measurement outputs keep their last value while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fb_count      <= 8'd0;
      freq_err      <= 5'd0;
      freq_err_sign <= 1'b0;
      meas_valid    <= 1'b0;
    end else begin
      meas_valid <= w_close;
      if (w_close) begin
        fb_count      <= w_fb_total;
        freq_err      <= w_err;
        freq_err_sign <= w_under;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_good_cnt <= 5'd0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_good_cnt <= w_good_next;
      locked     <= (w_state_next == S_LOCKED) || (w_state_next == S_HOLD);
      lock_lost  <= w_lost_next;
    end
  end

endmodule

// File: tb/tb_adpll_lock_det_5bit.sv
// Bench for adpll_lock_det_5bit: clock-synchronous stimulus of clk_ref/fb_clk,
// a window/FSM reference model pushing expected measurements to a scoreboard.
module tb_adpll_lock_det_5bit;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clk_ref = 1'b0;
  logic       fb_clk = 1'b0;
  logic [4:0] tol = 5'd1;
  logic [4:0] lock_thresh = 5'd3;
  logic [7:0] fb_count;
  logic [4:0] freq_err;
  logic       freq_err_sign;
  logic       meas_valid;
  logic       locked;
  logic       lock_lost;

  adpll_lock_det_5bit #(.WIN_LOG2(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .clk_ref       (clk_ref),
    .fb_clk        (fb_clk),
    .tol           (tol),
    .lock_thresh   (lock_thresh),
    .fb_count      (fb_count),
    .freq_err      (freq_err),
    .freq_err_sign (freq_err_sign),
    .meas_valid    (meas_valid),
    .locked        (locked),
    .lock_lost     (lock_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fb;
    int err;
    int sign;
    int lk;
    int lost;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_meas = 0;

  // Reference model state: 0 idle, 1 sync, 2 acq, 3 locked, 4 hold
  int m_rcnt, m_fcnt, m_state, m_good, last_fb;
  bit m_en, prev_ref, prev_fb;

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_rcnt  = 0;
    m_fcnt  = 0;
    m_good  = 0;
    m_state = 0;
  endtask

  task automatic model_close();
    exp_t e;
    int   d, th;
    bit   good;
    e.fb   = m_fcnt;
    d      = m_fcnt - N;
    e.sign = (d < 0) ? 1 : 0;
    if (d < 0) d = -d;
    e.err  = (d > 31) ? 31 : d;
    e.lost = 0;
    good   = (e.err <= int'(tol));
    th     = (lock_thresh == 5'd0) ? 1 : int'(lock_thresh);
    case (m_state)
      2: begin
        if (good) begin
          m_good++;
          if (m_good >= th) begin
            m_state = 3;
            m_good  = 0;
          end
        end else begin
          m_good = 0;
        end
      end
      3: if (!good) m_state = 4;
      4: begin
        if (good) m_state = 3;
        else begin
          m_state = 2;
          m_good  = 0;
          e.lost  = 1;
        end
      end
      default: m_state = 2;
    endcase
    e.lk    = (m_state == 3 || m_state == 4) ? 1 : 0;
    last_fb = e.fb;
    sb_q.push_back(e);
  endtask

  task automatic drive(bit r, bit f);
    @(negedge clk);
    clk_ref = r;
    fb_clk  = f;
    if (m_en) begin
      if (f && !prev_fb && m_fcnt < 255) m_fcnt++;
      if (r && !prev_ref) begin
        if (m_rcnt == N - 1) begin
          model_close();
          m_fcnt = 0;
          m_rcnt = 0;
        end else begin
          m_rcnt++;
        end
      end
    end
    prev_ref = r;
    prev_fb  = f;
  endtask

  // One reference period of per clk cycles carrying n evenly spaced fb edges.
  task automatic run_period(int per, int n);
    for (int c = 0; c < per; c++) begin
      bit r, f;
      int sp;
      r = (c < per / 2);
      f = 1'b0;
      if (n > 0) begin
        sp = per / n;
        f  = ((c / sp) < n) && ((c % sp) < sp / 2);
      end
      drive(r, f);
    end
  endtask

  task automatic run_window(int per, int total);
    for (int p = 0; p < N; p++)
      run_period(per, total / N + ((p < total % N) ? 1 : 0));
  endtask

  task automatic set_en(bit v);
    @(negedge clk);
    en   = v;
    m_en = v;
    model_clear();
    if (v) m_state = 1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_fb_count"}, fb_count, 0);
    chk({tag, "_freq_err"}, freq_err, 0);
    chk({tag, "_sign"}, freq_err_sign, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_lock_lost"}, lock_lost, 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (meas_valid) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", sb_q.size(), 1);
        end else begin
          mon_e = sb_q.pop_front();
          n_meas++;
          $display("meas %0d: fb_count=%0d freq_err=%0d sign=%0d locked=%0d lock_lost=%0d (exp %0d/%0d/%0d/%0d/%0d)",
                   n_meas, fb_count, freq_err, freq_err_sign, locked, lock_lost,
                   mon_e.fb, mon_e.err, mon_e.sign, mon_e.lk, mon_e.lost);
          chk("fb_count", fb_count, mon_e.fb);
          chk("freq_err", freq_err, mon_e.err);
          chk("freq_err_sign", freq_err_sign, mon_e.sign);
          chk("locked", locked, mon_e.lk);
          chk("lock_lost", lock_lost, mon_e.lost);
        end
      end else if (lock_lost) begin
        chk("lock_lost_without_meas", lock_lost, 0);
      end
    end
  end

  initial begin
    model_clear();
    m_en     = 1'b0;
    prev_ref = 1'b0;
    prev_fb  = 1'b0;
    last_fb  = 0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    set_en(1'b1);

    // Nominal lock: one discarded window then three good windows
    repeat (4) run_window(16, 16);
    chk("lock_after_4", locked, 1);

    // Single bad window is absorbed by HOLD
    run_window(16, 18);
    chk("hold_locked", locked, 1);
    run_window(16, 16);
    chk("relocked", locked, 1);

    // Two bad windows lose lock, then +2 error never locks at tol=1
    run_window(16, 18);
    run_window(16, 18);
    chk("lost_locked", locked, 0);
    repeat (3) run_window(16, 18);
    chk("never_lock_18", locked, 0);

    // Stuck-low feedback and a 20x overspeed feedback
    run_window(16, 0);
    run_window(80, 320);
    run_window(80, 320);
    repeat (4) run_window(16, 16);
    chk("lock_after_extremes", locked, 1);

    // Error exactly equal to tol counts as good
    tol = 5'd2;
    run_window(16, 18);
    chk("tol_boundary_locked", locked, 1);
    tol = 5'd1;

    // Reset in the middle of a window while locked
    for (int p = 0; p < 5; p++) run_period(16, 1);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    m_state = 1;
    repeat (4) run_window(16, 16);
    chk("relock_after_reset", locked, 1);

    // Disable while locked
    set_en(1'b0);
    @(negedge clk);
    chk("en_low_locked", locked, 0);
    chk("en_low_lock_lost", lock_lost, 0);
    chk("en_low_fb_held", fb_count, last_fb);
    repeat (5) @(negedge clk);
    chk("en_low_fb_still_held", fb_count, last_fb);
    set_en(1'b1);

    // lock_thresh of zero behaves as one
    lock_thresh = 5'd0;
    run_window(16, 16);
    chk("thresh0_sync", locked, 0);
    run_window(16, 16);
    chk("thresh0_locked", locked, 1);

    repeat (10) @(negedge clk);
    chk("sb_left", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
